// File: rtl/fip_32_iter_div_pkg.sv
// Shared constants and state encoding for the iterative fixed-point divider.
package fip_pkg;

  localparam logic [31:0] FIP_MAX      = 32'h7FFF_FFFF;
  localparam logic [31:0] FIP_MIN      = 32'h8000_0000;
  localparam int          FIP_FRA_BITS = 16;

  typedef enum logic [1:0] {
    FIP_DIV_IDLE = 2'd0,
    FIP_DIV_CALC = 2'd1,
    FIP_DIV_DONE = 2'd2
  } fip_div_state_t;

endpackage

// File: rtl/fip_32_iter_div_if.sv
// Request/response bundle between a divider client (master) and the divider (slave).
interface fip_32_iter_div_if;

  logic        i_en;
  logic [31:0] i_x;
  logic [31:0] i_y;
  logic [31:0] o_z;
  logic        o_busy;
  logic        o_valid;
  logic        o_dbz;

  modport master (
    output i_en, i_x, i_y,
    input  o_z, o_busy, o_valid, o_dbz
  );

  modport slave (
    input  i_en, i_x, i_y,
    output o_z, o_busy, o_valid, o_dbz
  );

endinterface

// File: rtl/fip_32_iter_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module fip_udiv_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] div_i,
  input  logic        bit_i,
  output logic [31:0] rem_o,
  output logic        q_o
);

  logic [32:0] shifted;
  logic [32:0] diff;

  // The remainder stays below the divisor (at most 2^31), so 33 bits hold the shifted value.
  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {1'b0, div_i};
  assign q_o     = (shifted >= {1'b0, div_i});
  assign rem_o   = q_o ? diff[31:0] : shifted[31:0];

endmodule

// File: rtl/fip_32_iter_div.sv
// Iterative signed Q(31-FRA_BITS).FRA_BITS divider, one quotient bit per clock.
// Define FIP_DIV_SAT_EN to saturate on overflow / divide-by-zero instead of wrapping.
module fip_32_iter_div
  import fip_pkg::*;
#(
  parameter int FRA_BITS = FIP_FRA_BITS
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  fip_32_iter_div_if.slave   bus
);

  localparam int N  = 32 + FRA_BITS;
  localparam int CW = $clog2(N + 1);

  fip_div_state_t state_q, state_d;
  logic [N-1:0]   dvd_q, dvd_d;
  logic [31:0]    rem_q, rem_d;
  logic [31:0]    div_q, div_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sign_q, sign_d;
  logic           dbz_q, dbz_d;
  logic [31:0]    z_q, z_d;
  logic           valid_q, valid_d;
  logic           dbzo_q, dbzo_d;

  logic [31:0]    absX;
  logic [31:0]    absY;
  logic [31:0]    stepRem;
  logic           stepQ;
  logic [31:0]    wrapZ;
  logic [31:0]    resultZ;

  assign absX = bus.i_x[31] ? -bus.i_x : bus.i_x;
  assign absY = bus.i_y[31] ? -bus.i_y : bus.i_y;

  fip_udiv_step u_step (
    .rem_i (rem_q),
    .div_i (div_q),
    .bit_i (dvd_q[N-1]),
    .rem_o (stepRem),
    .q_o   (stepQ)
  );

`ifdef FIP_DIV_SAT_EN
  logic xneg_q;
  logic posOvf;
  logic negOvf;

  always_ff @(posedge i_clk) begin
    if (!i_rstn)
      xneg_q <= 1'b0;
    else if (state_q == FIP_DIV_IDLE && bus.i_en)
      xneg_q <= bus.i_x[31];
  end
`endif

  // Quotient bits shift into the LSB end of the dividend register as it empties.
  always_comb begin
    wrapZ = sign_q ? -dvd_q[31:0] : dvd_q[31:0];
`ifdef FIP_DIV_SAT_EN
    posOvf = |dvd_q[N-1:31];
    negOvf = (|dvd_q[N-1:32]) || (dvd_q[31] && (|dvd_q[30:0]));
    if (dbz_q)
      resultZ = xneg_q ? FIP_MIN : FIP_MAX;
    else if (sign_q && negOvf)
      resultZ = FIP_MIN;
    else if (!sign_q && posOvf)
      resultZ = FIP_MAX;
    else
      resultZ = wrapZ;
`else
    resultZ = dbz_q ? 32'h0 : wrapZ;
`endif
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    dbz_d   = dbz_q;
    z_d     = z_q;
    valid_d = 1'b0;
    dbzo_d  = dbzo_q;
    case (state_q)
      FIP_DIV_IDLE: begin
        if (bus.i_en) begin
          sign_d  = bus.i_x[31] ^ bus.i_y[31];
          dvd_d   = {absX, {FRA_BITS{1'b0}}};
          div_d   = absY;
          dbz_d   = (bus.i_y == 32'h0);
          rem_d   = '0;
          cnt_d   = '0;
          state_d = FIP_DIV_CALC;
        end
      end
      FIP_DIV_CALC: begin
        rem_d = stepRem;
        dvd_d = {dvd_q[N-2:0], stepQ};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1))
          state_d = FIP_DIV_DONE;
      end
      FIP_DIV_DONE: begin
        z_d     = resultZ;
        dbzo_d  = dbz_q;
        valid_d = 1'b1;
        state_d = FIP_DIV_IDLE;
      end
      default: state_d = FIP_DIV_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= FIP_DIV_IDLE;
      dvd_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      dbz_q   <= 1'b0;
      z_q     <= '0;
      valid_q <= 1'b0;
      dbzo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      dbz_q   <= dbz_d;
      z_q     <= z_d;
      valid_q <= valid_d;
      dbzo_q  <= dbzo_d;
    end
  end

  // The result cycle is already back in IDLE but still counts as busy.
  assign bus.o_busy  = (state_q != FIP_DIV_IDLE) || valid_q;
  assign bus.o_z     = z_q;
  assign bus.o_valid = valid_q;
  assign bus.o_dbz   = dbzo_q;

endmodule

// File: tb/tb_fip_32_iter_div.sv
// Directed self-checking bench for fip_32_iter_div; expectations follow FIP_DIV_SAT_EN.
module tb_fip_32_iter_div;
  import fip_pkg::*;

`ifdef FIP_DIV_SAT_EN
  localparam logic [31:0] EXP_OVF    = 32'h7FFF_FFFF;
  localparam logic [31:0] EXP_DBZ    = 32'h8000_0000;
  localparam logic [31:0] EXP_MINOVF = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] EXP_OVF    = 32'hFF00_0000;
  localparam logic [31:0] EXP_DBZ    = 32'h0000_0000;
  localparam logic [31:0] EXP_MINOVF = 32'h8000_0000;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fip_32_iter_div_if bus ();

  fip_32_iter_div #(.FRA_BITS(FIP_FRA_BITS)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [31:0] x, input logic [31:0] y);
    bus.i_en = en;
    bus.i_x  = x;
    bus.i_y  = y;
  endtask

  // Starts one division and follows it until o_busy drops; pokeAt >= 0 injects a stray start.
  task automatic runDivision(input string tag, input logic [31:0] x, input logic [31:0] y,
                             input logic [31:0] expZ, input logic expDbz, input int pokeAt);
    int k;
    int validAt;
    int validCount;
    logic [31:0] z;
    logic dbz;
    applyStimulus(1'b1, x, y);
    tick();
    applyStimulus(1'b0, x, y);
    k = 0;
    validAt = -1;
    validCount = 0;
    z = 32'h0;
    dbz = 1'b0;
    while (bus.o_busy === 1'b1 && k < 100) begin
      if (bus.o_valid === 1'b1) begin
        validCount++;
        validAt = k;
        z = bus.o_z;
        dbz = bus.o_dbz;
      end
      if (k == pokeAt) applyStimulus(1'b1, 32'h0005_0000, 32'h0001_0000);
      else             applyStimulus(1'b0, x, y);
      tick();
      k++;
    end
    checkOutput({tag, ".z"}, z, expZ);
    checkOutput({tag, ".dbz"}, {31'h0, dbz}, {31'h0, expDbz});
    checkOutput({tag, ".latency"}, 32'(validAt), 32'd49);
    checkOutput({tag, ".busyCycles"}, 32'(k), 32'd50);
    checkOutput({tag, ".validCount"}, 32'(validCount), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    int firstValid;
    int secondValid;
    int strayValid;
    logic [31:0] firstZ;

    applyStimulus(1'b0, 32'h0, 32'h0);
    rstn = 1'b0;
    repeat (3) tick();
    checkOutput("reset.z", bus.o_z, 32'h0);
    checkOutput("reset.busy", {31'h0, bus.o_busy}, 32'h0);
    checkOutput("reset.valid", {31'h0, bus.o_valid}, 32'h0);
    checkOutput("reset.dbz", {31'h0, bus.o_dbz}, 32'h0);
    rstn = 1'b1;
    tick();

    runDivision("div3by2",    32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, -1);
    runDivision("negDiv",     32'hFFF8_8000, 32'h0002_8000, 32'hFFFD_0000, 1'b0, -1);
    runDivision("oneThird",   32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1'b0, -1);
    runDivision("negThird",   32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 1'b0, -1);
    runDivision("overflow",   32'h7FFF_0000, 32'h0000_0100, EXP_OVF,       1'b0, -1);
    runDivision("divByZero",  32'hFFFF_0000, 32'h0000_0000, EXP_DBZ,       1'b1, -1);
    runDivision("minByNeg1",  32'h8000_0000, 32'hFFFF_0000, EXP_MINOVF,    1'b0, -1);
    runDivision("minByOne",   32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, -1);
    runDivision("strayStart", 32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 10);

    // Hold the start request high: a new operation begins every 50 cycles.
    applyStimulus(1'b1, 32'h0001_0000, 32'h0003_0000);
    tick();
    firstValid = -1;
    secondValid = -1;
    firstZ = 32'h0;
    for (int i = 0; i < 120; i++) begin
      if (bus.o_valid === 1'b1) begin
        if (firstValid < 0) begin
          firstValid = i;
          firstZ = bus.o_z;
        end else if (secondValid < 0) begin
          secondValid = i;
        end
      end
      tick();
    end
    checkOutput("heldEn.firstValid", 32'(firstValid), 32'd49);
    checkOutput("heldEn.secondValid", 32'(secondValid), 32'd99);
    checkOutput("heldEn.z", firstZ, 32'h0000_5555);
    applyStimulus(1'b0, 32'h0, 32'h0);
    k = 0;
    while (bus.o_busy === 1'b1 && k < 100) begin
      tick();
      k++;
    end
    checkOutput("heldEn.drained", {31'h0, bus.o_busy}, 32'h0);

    // Reset in the middle of CALC discards the operation.
    runDivision("preReset", 32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, -1);
    applyStimulus(1'b1, 32'h0007_0000, 32'h0002_0000);
    tick();
    applyStimulus(1'b0, 32'h0007_0000, 32'h0002_0000);
    repeat (20) tick();
    rstn = 1'b0;
    tick();
    checkOutput("midReset.busy", {31'h0, bus.o_busy}, 32'h0);
    checkOutput("midReset.z", bus.o_z, 32'h0);
    checkOutput("midReset.valid", {31'h0, bus.o_valid}, 32'h0);
    rstn = 1'b1;
    strayValid = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.o_valid === 1'b1) strayValid++;
      tick();
    end
    checkOutput("midReset.noValid", 32'(strayValid), 32'd0);
    runDivision("postReset", 32'h0005_0000, 32'h0002_0000, 32'h0002_8000, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
